// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: rotation table, PC-1/PC-2 index tables
// (DES 1-based bit numbering, MSB = bit 1), FSM state type and helpers.
package des_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [6:0] PC1 [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // DES bit n of the 64-bit key lives at key[64-n].
  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = key[7'd64 - PC1[i]];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
    return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

  function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
    return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} register to a 48-bit
// subkey; subkey[47] is DES bit 1.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[47-i] = cd[6'd56 - PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one subkey per valid/ready handshake, encrypt
// or decrypt order. Optional odd-parity key check: DES_KEY_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        subkey_ready,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [3:0]  key_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  // Handshake: a subkey transfers on a rising edge where subkey_valid and
  // subkey_ready are both high; valid depends only on registered state.

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [55:0] cd_q, cd_d;
  logic        done_q, done_d;
  logic        perr_q, perr_d;
  logic        key_ok;
  logic        hs;
  logic [55:0] pc1_key;

  assign pc1_key = pc1_perm(key_in);
  assign hs      = (state_q == RUN) && subkey_ready;

`ifdef DES_KEY_PARITY_CHECK_EN
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key_in[b*8 +: 8])) key_ok = 1'b0;
    end
  end
`else
  assign key_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    cd_d    = cd_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (key_ok) begin
            state_d = RUN;
            cnt_d   = 4'd0;
            dir_d   = decrypt;
            // Decrypt starts from C0D0, which equals C16D16.
            cd_d    = decrypt ? pc1_key : rotl_cd(pc1_key, SHIFT[0]);
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            cd_d  = dir_q ? rotr_cd(cd_q, SHIFT[4'd15 - cnt_q])
                          : rotl_cd(cd_q, SHIFT[cnt_q + 4'd1]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
      cd_q    <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      cd_q    <= cd_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign key_idx      = dir_q ? (4'd15 - cnt_q) : cnt_q;
  assign done         = done_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1
// worked-example subkeys; parity cases depend on DES_KEY_PARITY_CHECK_EN.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  key_idx;
  logic        busy;
  logic        done;
  logic        parity_err;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic [47:0] k_tab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key_in       (key_in),
    .subkey_ready (subkey_ready),
    .subkey_valid (subkey_valid),
    .subkey       (subkey),
    .key_idx      (key_idx),
    .busy         (busy),
    .done         (done),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic dec, input logic [63:0] key);
    start   = 1'b1;
    decrypt = dec;
    key_in  = key;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
    key_in  = '0;
  endtask

  // Full run with ready held high; checks every cycle 1..16 and the done cycle.
  task automatic full_run(input logic dec, input string tag);
    logic [3:0] idx;
    subkey_ready = 1'b1;
    do_start(dec, KEY);
    for (int i = 0; i < 16; i++) begin
      idx = dec ? 4'(15 - i) : 4'(i);
      chk({tag, "_valid"}, 64'(subkey_valid), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_idx"}, 64'(key_idx), 64'(idx));
      chk({tag, "_subkey"}, 64'(subkey), 64'(k_tab[idx]));
      chk({tag, "_done_low"}, 64'(done), 64'd0);
      tick();
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_valid_end"}, 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    int n;
    int cyc;
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = '0; subkey_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_perr", 64'(parity_err), 64'd0);
    chk("rst_idx", 64'(key_idx), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);

    full_run(1'b0, "enc");
    tick();
    chk("done_pulse_one", 64'(done), 64'd0);

    full_run(1'b1, "dec");
    tick();

    // Pseudo-random back-pressure; each valid cycle must show the next subkey.
    do_start(1'b0, KEY);
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      subkey_ready = 1'($urandom_range(0, 1));
      chk("bp_valid", 64'(subkey_valid), 64'd1);
      chk("bp_idx", 64'(key_idx), 64'(n));
      chk("bp_subkey", 64'(subkey), 64'(k_tab[n]));
      if (subkey_ready) n++;
      tick();
      cyc++;
    end
    chk("bp_count", 64'(n), 64'd16);
    chk("bp_done", 64'(done), 64'd1);
    subkey_ready = 1'b1;
    tick();

    // Reset while cnt = 7 aborts with no done pulse.
    do_start(1'b0, KEY);
    for (int i = 0; i < 7; i++) tick();
    chk("abort_idx7", 64'(key_idx), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 64'(subkey_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    tick();
    chk("abort_done2", 64'(done), 64'd0);
    do_start(1'b0, KEY);
    chk("restart_idx", 64'(key_idx), 64'd0);
    chk("restart_subkey", 64'(subkey), 64'(k_tab[0]));
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Start during RUN is ignored; start in the done cycle begins a new run.
    do_start(1'b0, KEY);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        start = 1'b1; decrypt = 1'b1; key_in = 64'h0;
      end else begin
        start = 1'b0; decrypt = 1'b0; key_in = 64'h0;
      end
      chk("ign_idx", 64'(key_idx), 64'(i));
      chk("ign_subkey", 64'(subkey), 64'(k_tab[i]));
      tick();
    end
    chk("ign_done", 64'(done), 64'd1);
    start = 1'b1; decrypt = 1'b1; key_in = KEY;
    tick();
    start = 1'b0; decrypt = 1'b0; key_in = '0;
    chk("b2b_valid", 64'(subkey_valid), 64'd1);
    chk("b2b_idx", 64'(key_idx), 64'd15);
    chk("b2b_subkey", 64'(subkey), 64'(k_tab[15]));
    rst = 1'b1;
    tick();
    rst = 1'b0;

`ifdef DES_KEY_PARITY_CHECK_EN
    do_start(1'b0, 64'h0);
    chk("par_err", 64'(parity_err), 64'd1);
    chk("par_valid", 64'(subkey_valid), 64'd0);
    tick();
    chk("par_err_pulse", 64'(parity_err), 64'd0);
    chk("par_valid2", 64'(subkey_valid), 64'd0);
    chk("par_done", 64'(done), 64'd0);
    do_start(1'b0, KEY);
    chk("par_ok_err", 64'(parity_err), 64'd0);
    chk("par_ok_valid", 64'(subkey_valid), 64'd1);
    chk("par_ok_subkey", 64'(subkey), 64'(k_tab[0]));
`else
    do_start(1'b0, 64'h0);
    chk("nopar_err", 64'(parity_err), 64'd0);
    chk("nopar_valid", 64'(subkey_valid), 64'd1);
    chk("nopar_subkey", 64'(subkey), 64'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
